clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
Programmable clock divider and tick generator. It generalises the fixed 100 MHz-to-1 Hz divider: the counter width and the reset divisor are parameters, and software can change the divisor at runtime. It sits on the CPU I/O bus next to the GPIO block and uses the same address, write-data and write-enable style. It provides a square-wave divided clock, a one-cycle tick strobe, and a wrapping event counter.

Parameters:
CNT_W, 32, width of the divide counter, the limit registers and the event counter (range 2..32).
DEFAULT_LIMIT, 49_999_999, reset value of the active and pending half-period limits (gives 1 Hz from 100 MHz).
DEFAULT_EN, 1, reset value of CTRL.enable.

Ports:
clk_in  in  1  system clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-low reset.
io_addr  in  5  register byte address; only bits [3:2] are decoded.
io_wdata  in  32  write data.
io_we  in  1  write strobe; a write occurs on each clk_in edge where io_we is 1.
clk_out  out  1  divided clock, registered.
tick  out  1  one-clk_in-cycle pulse at each terminal count, registered.
rd_data  out  32  registered read data for io_addr, one cycle of latency.

Behaviour:
- Reset (reset=0, asynchronous):
  - counter=0, clk_out=0, tick=0, rd_data=0, evt_cnt=0.
  - active_limit=pending_limit=DEFAULT_LIMIT[CNT_W-1:0].
  - enable=DEFAULT_EN.
  - Release of reset is used synchronously.
- Register map (io_addr[3:2]):
  - 0 = CTRL: bit0 enable (R/W); bit1 restart (write-1, self-clearing, reads 0).
  - 1 = LIMIT: writes pending_limit; reads pending_limit.
  - 2 = COUNT: read-only current counter; writes are ignored.
  - 3 = EVENTS: reads evt_cnt; any write clears it to 0.
  - Read values are zero-extended to 32 bits. Write data is truncated to CNT_W bits.
- Counting (enable=1):
  - Each cycle, counter increments by 1.
  - Terminal count (TC) is counter==active_limit. At TC:
    - counter<=0 and clk_out<=~clk_out.
    - tick<=1 for exactly one cycle.
    - evt_cnt<=evt_cnt+1, wrapping modulo 2^CNT_W.
    - active_limit<=pending_limit.
  - Output period is 2*(active_limit+1) clk_in cycles. A limit of 0 gives clk_in/2, with tick asserted every cycle.
- Glitch-free update:
  - A LIMIT write while enabled changes only pending_limit.
  - The new value takes effect at the next TC, so the current half-period always completes with the old limit.
  - A LIMIT write on the same cycle as TC loads io_wdata directly into active_limit (the write wins).
  - A LIMIT write while enable=0 updates both pending_limit and active_limit.
- Disable (enable written to 0):
  - On the next edge: counter<=0, clk_out<=0, tick<=0.
  - evt_cnt and the limits are held.
  - Re-enabling starts a full low half-period from counter=0.
- Restart (CTRL write with bit1=1):
  - counter<=0, clk_out<=0, tick<=0, active_limit<=pending_limit.
  - enable takes io_wdata[0] in the same write.
  - Restart has priority over a TC in the same cycle: no tick is issued and evt_cnt is not incremented.
- EVENTS clear in the same cycle as a TC: the result is 0 (clear wins).
- The invariant counter<=active_limit always holds, because active_limit changes only at TC, at restart, or while disabled.
- Reads:
  - rd_data<=mux(io_addr) every cycle, independent of io_we.
  - A read of a register written in cycle N returns the new value in cycle N+2 (pre-write value in N+1).
- Reset asserted mid-period: all state returns immediately to its reset values, and clk_out drops to 0 asynchronously.

Test Plan:
- Reset with DEFAULT_LIMIT overridden to 3 -> clk_out toggles every 4 cycles (period 8), tick pulses every 4th cycle, EVENTS=5 after 20 cycles.
- LIMIT=1 written 2 cycles into a limit-3 half-period -> that half-period still lasts 4 cycles; subsequent half-periods last 2 cycles; no short pulse on clk_out.
- LIMIT write coinciding with TC (limit 3, write 0) -> the very next half-period is 1 cycle, and tick is then high every cycle.
- CTRL=0 mid-count, then LIMIT=5, then CTRL=1 -> clk_out=0 while disabled, COUNT reads 0, first high edge appears exactly 6 cycles after enable.
- CTRL=0x3 on a TC cycle -> no tick, EVENTS unchanged, counter=0; EVENTS write on a TC cycle -> EVENTS reads 0.
- Assert reset for 1 cycle mid-period with clk_out=1 -> clk_out, tick and rd_data are 0 without a clock edge; limits return to DEFAULT_LIMIT.

Source files
------------

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock divider with tick strobe, event counter and bus registers
module clk_div_prog #(
    parameter int          CNT_W         = 32,
    parameter logic [31:0] DEFAULT_LIMIT = 32'd49_999_999,
    parameter bit          DEFAULT_EN    = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [4:0]  io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_we,
    output logic        clk_out,
    output logic        tick,
    output logic [31:0] rd_data
);

    localparam logic [CNT_W-1:0] RST_LIMIT = DEFAULT_LIMIT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LIMIT  = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_EVENTS = 2'd3;

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] active_limit;
    logic [CNT_W-1:0] pending_limit;
    logic [CNT_W-1:0] evt_cnt;
    logic             enable;

    logic [1:0]       sel;
    logic [CNT_W-1:0] wdata_t;
    logic             wr_ctrl;
    logic             wr_limit;
    logic             wr_events;
    logic             restart;
    logic             halt;
    logic             tc;
    logic             tc_eff;
    logic [31:0]      rd_next;
    logic             unused_bits;

    assign sel       = io_addr[3:2];
    assign wdata_t   = io_wdata[CNT_W-1:0];
    assign wr_ctrl   = io_we && (sel == REG_CTRL);
    assign wr_limit  = io_we && (sel == REG_LIMIT);
    assign wr_events = io_we && (sel == REG_EVENTS);
    assign restart   = wr_ctrl && io_wdata[1];
    // A restart or a disabling CTRL write overrides any terminal count on the same edge
    assign halt      = restart || (wr_ctrl && !io_wdata[0]);
    assign tc        = enable && (counter == active_limit);
    assign tc_eff    = tc && !halt;

    assign unused_bits = ^{io_addr[4], io_addr[1:0], io_wdata};

    // Enable bit of CTRL
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            enable <= DEFAULT_EN;
        end else if (wr_ctrl) begin
            enable <= io_wdata[0];
        end
    end

    // Divide counter, square-wave output and tick strobe
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (halt || !enable) begin
            counter <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (tc) begin
            counter <= '0;
            clk_out <= ~clk_out;
            tick    <= 1'b1;
        end else begin
            counter <= counter + ONE;
            tick    <= 1'b0;
        end
    end

    // Limits: pending takes every write, active only at TC, restart or while stopped
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pending_limit <= RST_LIMIT;
            active_limit  <= RST_LIMIT;
        end else begin
            if (wr_limit) begin
                pending_limit <= wdata_t;
            end
            if (restart) begin
                active_limit <= pending_limit;
            end else if (wr_limit && (tc || !enable)) begin
                active_limit <= wdata_t;
            end else if (tc) begin
                active_limit <= pending_limit;
            end
        end
    end

    // Wrapping event counter; a clear beats a same-cycle increment
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            evt_cnt <= '0;
        end else if (wr_events) begin
            evt_cnt <= '0;
        end else if (tc_eff) begin
            evt_cnt <= evt_cnt + ONE;
        end
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_next = '0;
        case (sel)
            REG_CTRL:   rd_next[0]         = enable;
            REG_LIMIT:  rd_next[CNT_W-1:0] = pending_limit;
            REG_COUNT:  rd_next[CNT_W-1:0] = counter;
            REG_EVENTS: rd_next[CNT_W-1:0] = evt_cnt;
            default:    rd_next            = '0;
        endcase
    end

    // Registered read data, one cycle behind the address
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog
module tb_clk_div_prog;

    logic        clk_in;
    logic        reset;
    logic [4:0]  io_addr;
    logic [31:0] io_wdata;
    logic        io_we;
    logic        clk_out;
    logic        tick;
    logic [31:0] rd_data;

    int n_vec;
    int n_err;

    clk_div_prog #(
        .CNT_W         (8),
        .DEFAULT_LIMIT (32'd3),
        .DEFAULT_EN    (1'b1)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_we    (io_we),
        .clk_out  (clk_out),
        .tick     (tick),
        .rd_data  (rd_data)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        io_addr  = addr;
        io_wdata = data;
        io_we    = 1'b1;
        step();
        io_we    = 1'b0;
    endtask

    task automatic expect_seq(input string tag, input int n, input logic [31:0] tick_bits,
                              input logic [31:0] clk_bits);
        for (int i = 0; i < n; i++) begin
            step();
            check({tag, "_tick"}, {31'd0, tick}, {31'd0, tick_bits[i]});
            check({tag, "_clk"}, {31'd0, clk_out}, {31'd0, clk_bits[i]});
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        io_addr  = 5'd12;
        io_wdata = '0;
        io_we    = 1'b0;

        #3;
        check("rst_clk", {31'd0, clk_out}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        step();
        reset = 1'b1;

        // limit 3 from reset: tick every 4th edge, clk_out period 8
        for (int k = 1; k <= 20; k++) begin
            step();
            check("dflt_tick", {31'd0, tick}, {31'd0, (k % 4) == 0});
            check("dflt_clk", {31'd0, clk_out}, ((k / 4) % 2));
            check("dflt_evt", rd_data, (k - 1) / 4);
        end
        io_addr = 5'd12;
        step();
        check("dflt_evt20", rd_data, 32'd5);

        // limit 0: tick every cycle, event counter wraps at 8 bits
        wr(5'd4, 32'd0);
        wr(5'd0, 32'd3);
        wr(5'd12, 32'd0);
        check("lim0_tick", {31'd0, tick}, 32'd1);
        repeat (256) step();
        check("wrap_255", rd_data, 32'd255);
        step();
        check("wrap_0", rd_data, 32'd0);

        // LIMIT=1 written two cycles into a limit-3 half-period
        wr(5'd4, 32'd3);
        wr(5'd0, 32'd3);
        step();
        wr(5'd4, 32'd1);
        check("glitch_w_clk", {31'd0, clk_out}, 32'd0);
        expect_seq("glitch", 8, 32'b1010_1010, 32'b0110_0110);

        // LIMIT=0 written on the TC edge of a limit-3 half-period
        wr(5'd4, 32'd3);
        wr(5'd0, 32'd3);
        repeat (3) step();
        wr(5'd4, 32'd0);
        check("tcw_tick", {31'd0, tick}, 32'd1);
        check("tcw_clk", {31'd0, clk_out}, 32'd1);
        expect_seq("tcw", 6, 32'b11_1111, 32'b10_1010);

        // disable mid-count, reprogram while stopped, re-enable
        wr(5'd4, 32'd3);
        wr(5'd0, 32'd3);
        repeat (5) step();
        check("pre_dis_clk", {31'd0, clk_out}, 32'd1);
        wr(5'd0, 32'd0);
        check("dis_clk", {31'd0, clk_out}, 32'd0);
        check("dis_tick", {31'd0, tick}, 32'd0);
        expect_seq("dis", 3, 32'b000, 32'b000);
        io_addr = 5'd8;
        step();
        check("dis_count", rd_data, 32'd0);
        io_addr = 5'd0;
        step();
        check("dis_ctrl", rd_data, 32'd0);
        wr(5'd4, 32'h0000_0105);
        io_addr = 5'd4;
        step();
        check("trunc_limit", rd_data, 32'd5);
        wr(5'd0, 32'd1);
        expect_seq("reen", 6, 32'b10_0000, 32'b10_0000);

        // restart on a TC edge, then EVENTS clear on a TC edge
        wr(5'd12, 32'd0);
        repeat (4) step();
        wr(5'd0, 32'd3);
        check("rs_tick", {31'd0, tick}, 32'd0);
        check("rs_clk", {31'd0, clk_out}, 32'd0);
        io_addr = 5'd8;
        step();
        check("rs_count", rd_data, 32'd0);
        io_addr = 5'd12;
        step();
        check("rs_evt", rd_data, 32'd0);
        repeat (3) step();
        wr(5'd12, 32'd0);
        check("clr_tick", {31'd0, tick}, 32'd1);
        step();
        check("clr_evt", rd_data, 32'd0);
        repeat (5) step();
        step();
        check("post_clr_evt", rd_data, 32'd1);

        // asynchronous reset while clk_out is high
        repeat (5) step();
        check("pre_rst_clk", {31'd0, clk_out}, 32'd1);
        check("pre_rst_rd", rd_data, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_clk", {31'd0, clk_out}, 32'd0);
        check("arst_tick", {31'd0, tick}, 32'd0);
        check("arst_rd", rd_data, 32'd0);
        @(posedge clk_in);
        #1;
        reset   = 1'b1;
        io_addr = 5'd4;
        step();
        check("arst_limit", rd_data, 32'd3);
        io_addr = 5'd0;
        step();
        check("arst_ctrl", rd_data, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
